// File: rtl/merge.sv
// merge: round-robin N-to-1 merge of native-bus masters onto one slave port.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   m_req    concatenated master requests, master 0 in the LSBs, valid is each request's MSB
//   m_resp   concatenated master responses {rdata[32], ready}, master 0 in the LSBs
//   s_req    slave request, held stable for the whole transaction
//   s_resp   slave response {rdata[32], ready}
//   grant_id index of the master being served; holds the last value while idle
module merge #(
    parameter int TYPE = 0,
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    localparam int REQ_W = (TYPE == 0) ? ADDR_W + 37 : ADDR_W + 1,
    localparam int RESP_W = 33,
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [GW-1:0]               grant_id
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [GW-1:0] LAST = GW'(N_MASTERS - 1);
    state_t state, state_nxt;
    logic [GW-1:0] ptr, grant_q, sel;
    logic [REQ_W-1:0] req_q;
    logic any;
    // Scan from the farthest offset down so the first valid master at or after ptr wins.
    always_comb begin
        sel = ptr;
        any = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_req[((int'(ptr) + i) % N_MASTERS) * REQ_W + REQ_W - 1]) begin
                sel = GW'((int'(ptr) + i) % N_MASTERS);
                any = 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        m_resp = '0;
        if (state == IDLE) state_nxt = any ? BUSY : IDLE;
        else if (s_resp[0]) begin
            state_nxt = IDLE;
            m_resp[int'(grant_q) * RESP_W +: RESP_W] = s_resp;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            grant_q <= '0;
            req_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any) begin
                req_q <= m_req[int'(sel) * REQ_W +: REQ_W];
                grant_q <= sel;
            end else if (state == BUSY && s_resp[0]) begin
                req_q <= '0;
                ptr <= (grant_q == LAST) ? '0 : grant_q + 1'b1;
            end
        end
    end
    // req_q is cleared on completion and reset, so it doubles as the idle-zero slave request.
    assign s_req = req_q;
    assign grant_id = grant_q;
endmodule

// File: tb/tb_merge.sv
// tb_merge: directed bench for merge with a transaction-level reference model and literal pins.
module tb_merge;
    localparam int N = 2;
    localparam int RQ = 69;
    localparam int RS = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*RQ-1:0] m_req = '0;
    logic [N*RS-1:0] m_resp;
    logic [RQ-1:0] s_req;
    logic [RS-1:0] s_resp = '0;
    logic gid;

    logic [3*17-1:0] m3_req = '0;
    logic [3*33-1:0] m3_resp;
    logic [16:0] s3_req;
    logic [32:0] s3_resp = '0;
    logic [1:0] gid3;

    int n_cmp = 0;
    int n_err = 0;

    merge #(.TYPE(0), .N_MASTERS(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .grant_id(gid)
    );

    merge #(.TYPE(1), .N_MASTERS(3), .ADDR_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .m_req(m3_req), .m_resp(m3_resp),
        .s_req(s3_req), .s_resp(s3_resp), .grant_id(gid3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RQ-1:0] mk(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    // Transaction-level model: who owns the slave, what request it was given, where the scan starts.
    bit mb;
    int mo, mp, mg, mc;
    bit mf;
    logic [RQ-1:0] mh;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb = 0; mo = 0; mp = 0; mg = 0; mh = '0;
        end else if (!mb) begin
            mf = 0;
            for (int k = 0; k < N; k++) begin
                mc = (mp + k) % N;
                if (!mf && m_req[mc*RQ+RQ-1]) begin
                    mf = 1; mb = 1; mo = mc; mg = mc; mh = m_req[mc*RQ +: RQ];
                end
            end
        end else if (s_resp[0]) begin
            mb = 0;
            mp = (mo + 1) % N;
        end
    end

    always @(negedge clk) begin
        chk("model_s_req", s_req, mb ? mh : '0);
        for (int i = 0; i < N; i++)
            chk("model_m_resp", m_resp[i*RS +: RS], (mb && mo == i && s_resp[0]) ? s_resp : '0);
        chk("model_grant_id", gid, mg);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        m_req = '0; s_resp = '0; m3_req = '0; s3_resp = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int rc0, rc1;
    logic [31:0] rd;
    int eg[4] = '{0, 1, 0, 1};

    initial begin
        step();
        chk("reset_s_req", s_req, '0);
        chk("reset_m_resp", m_resp, '0);
        chk("reset_grant_id", gid, 0);
        do_reset();

        // single master
        m_req[RQ-1:0] = mk(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        step();
        chk("single_s_req_c1", s_req, {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
        step();
        step();
        s_resp = {32'h12345678, 1'b1};
        #1;
        chk("single_m_resp_c3", m_resp, {33'h0, 32'h12345678, 1'b1});
        step();
        m_req = '0; s_resp = '0;
        #1;
        chk("single_idle_c4", s_req, '0);
        step();
        chk("single_no_regrant", s_req, '0);

        // contention: both masters valid continuously
        do_reset();
        m_req = {mk(1'b1, 32'h2000, 32'h2, 4'h3), mk(1'b1, 32'h1000, 32'h1, 4'h1)};
        rc0 = 0; rc1 = 0;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("cont_grant_id", gid, eg[g]);
            step();
            rd = 32'hC0DE0000 + g;
            s_resp = {rd, 1'b1};
            #1;
            chk("cont_m_resp", m_resp, (eg[g] == 0) ? {33'h0, rd, 1'b1} : {rd, 1'b1, 33'h0});
            rc0 += int'(m_resp[0]);
            rc1 += int'(m_resp[RS]);
            step();
            s_resp = '0;
        end
        chk("cont_ready_m0", rc0, 2);
        chk("cont_ready_m1", rc1, 2);
        m_req = '0;
        step();

        // stability while the slave stalls
        do_reset();
        m_req[RQ-1:0] = mk(1'b1, 32'h100, 32'h1111, 4'h3);
        step();
        m_req[RQ-1:0] = mk(1'b0, 32'h200, 32'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stable_s_req", s_req, {1'b1, 32'h100, 32'h1111, 4'h3});
        end
        s_resp = {32'h5, 1'b1};
        step();
        s_resp = '0;
        #1;
        chk("stable_done", s_req, '0);

        // asynchronous reset mid-transaction
        do_reset();
        m_req = {mk(1'b1, 32'h300, 32'h3, 4'h2), {RQ{1'b0}}};
        step();
        chk("rst_grant_m1", gid, 1);
        s_resp = {32'hFFFF0000, 1'b1};
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_s_req", s_req, '0);
        chk("rst_async_m_resp", m_resp, '0);
        chk("rst_async_grant_id", gid, 0);
        s_resp = '0;
        step();
        step();
        rst_n = 1'b1;
        m_req = {mk(1'b1, 32'h300, 32'h3, 4'h2), mk(1'b1, 32'h400, 32'h4, 4'h4)};
        step();
        chk("rst_after_grant", gid, 0);
        chk("rst_after_s_req", s_req, {1'b1, 32'h400, 32'h4, 4'h4});
        m_req = '0;
        s_resp = {32'h1, 1'b1};
        step();
        s_resp = '0;

        // spurious slave ready while idle
        do_reset();
        s_resp = {32'hAAAA5555, 1'b1};
        #1;
        chk("spur_m_resp", m_resp, '0);
        step();
        chk("spur_s_req", s_req, '0);
        chk("spur_grant_id", gid, 0);
        s_resp = '0;

        // three masters, round-robin wrap
        do_reset();
        m3_req[17 +: 17] = {1'b1, 16'h0011};
        step();
        chk("rr3_first_grant", gid3, 1);
        chk("rr3_first_s_req", s3_req, {1'b1, 16'h0011});
        s3_resp = {32'h1, 1'b1};
        #1;
        chk("rr3_first_m_resp", m3_resp, {33'h0, 32'h1, 1'b1, 33'h0});
        step();
        s3_resp = '0;
        m3_req[0 +: 17] = {1'b1, 16'h0000};
        step();
        chk("rr3_wrap_grant", gid3, 0);
        chk("rr3_wrap_s_req", s3_req, {1'b1, 16'h0000});
        s3_resp = {32'h2, 1'b1};
        step();
        s3_resp = '0;
        step();
        chk("rr3_next_grant", gid3, 1);
        m3_req = '0;
        s3_resp = {32'h3, 1'b1};
        step();
        s3_resp = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
